isqrt_share_arb: RTL and testbench
==================================

Name: isqrt_share_arb

Overview:
- Round-robin arbiter that shares one pipelined isqrt instance (fixed latency, valid-only, no stall) among N requesters.
- Tracks each issued request's requester ID through a tag shift register aligned with the isqrt pipeline and routes each result back to its owner.
- Bounds outstanding requests per requester.
- Sits between formula-level pipelines and a single shared isqrt when area matters more than per-path throughput.

Parameters:
N, 4, number of requesters (2..8)
ISQRT_LAT, 16, cycles from isqrt x_vld to y_vld (fixed, no backpressure)
MAX_OUT, 4, max in-flight requests per requester (1..15)

Ports:
clk  in  1  clock, all flops on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_vld  in  N  per-requester request valid
req_x  in  N*32  per-requester operand, slice i = bits [32*i+31:32*i]
req_rdy  out  N  per-requester accept (at most one bit set)
rsp_vld  out  N  per-requester result valid (at most one bit set), single-cycle pulse
rsp_y  out  32  result bus shared by all requesters, qualified by rsp_vld
sq_x_vld  out  1  to isqrt x_vld
sq_x  out  32  to isqrt x
sq_y_vld  in  1  from isqrt y_vld
sq_y  in  32  from isqrt y
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0, asynchronous) clears: req_rdy=0, rsp_vld=0, sq_x_vld=0, err=0, RR pointer=0, all tag valids=0, all outstanding counters=0. Data registers (sq_x, rsp_y, tag IDs) are not reset.
- Eligible(i) = req_vld[i] && outstanding[i] < MAX_OUT.
- Grant logic (combinational):
  - req_rdy is one-hot: the first eligible index at or after the pointer, searching upward and wrapping modulo N.
  - req_rdy never depends on another requester's rdy.
  - While rst=0, req_rdy=0.
- Accept when req_vld[i] && req_rdy[i]. At most one accept per cycle.
- Pointer:
  - After an accept by i, pointer <= (i+1) mod N.
  - With no accept, the pointer holds.
- Issue (registered):
  - The cycle after an accept: sq_x_vld=1 and sq_x = accepted operand.
  - Otherwise sq_x_vld=0 and sq_x holds its previous value (no toggling, to save power).
- Tag pipeline:
  - ISQRT_LAT stages of {valid, id[$clog2(N)-1:0]}, entered in step with sq_x_vld.
  - ID stages load only when the entering valid=1.
- Return:
  - When sq_y_vld=1 and the tail tag valid=1: the next cycle rsp_vld[id]=1 and rsp_y=sq_y.
  - rsp_y holds when no result returns.
- Latency: accept at cycle T -> sq_x_vld at T+1 -> sq_y_vld at T+1+ISQRT_LAT -> rsp_vld at T+2+ISQRT_LAT. Throughput is 1 result/cycle.
- Outstanding[i]:
  - +1 on accept by i; -1 on rsp_vld[i].
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT; never goes below 0.
- Error, when sq_y_vld differs from the tail tag valid:
  - err <= 1, sticky until reset.
  - Stray sq_y_vld (no tag): result dropped, no rsp_vld.
  - Missing sq_y_vld (tag present): that tag is discarded and the owner's outstanding count is decremented, so the requester is not starved.
- Reset mid-operation: all in-flight tags are dropped. No rsp_vld is asserted for requests accepted before reset, even if the isqrt still emits them. Any such emission after reset is a stray and sets err. The bench masks this error in the reset scenario.
- Requesters must accept rsp_vld unconditionally; there is no result backpressure.

Test Plan:
1. Single request: req_vld[0]=1, x=144 at cycle 0 -> req_rdy[0]=1 at cycle 0; sq_x_vld=1 with sq_x=144 at cycle 1; rsp_vld=0001 with rsp_y=12 at cycle 18; err=0.
2. Full contention: all four req_vld held high with x=4, 9, 16, 25 -> grants 0,1,2,3,0,... one per cycle; results 2, 3, 4, 5 on rsp_vld bits 0..3 in the same order, back-to-back.
3. Outstanding limit: only req_vld[1] held high -> four accepts in cycles 0..3, then req_rdy[1]=0 until cycle 18; one new accept per returned result thereafter.
4. Boundaries: x=0 -> rsp_y=0; x=0xFFFFFFFF -> rsp_y=65535; x=1 -> rsp_y=1.
5. Reset mid-flight: three requests accepted, then rst=0 for 2 cycles at cycle 5 -> outputs cleared immediately (asynchronously); no rsp_vld ever asserted for those requests; counters at 0; a new request afterwards completes normally.
6. Protocol error: force sq_y_vld=1 while no tag is in flight -> err=1 the next cycle and stays 1; no rsp_vld; normal traffic continues correctly.

Source files
------------

// File: rtl/isqrt_share_arb.sv
// isqrt_share_arb: round-robin sharing of one fixed-latency isqrt pipeline among N requesters,
// with per-requester in-flight limits and ID tags that route each result back to its owner.
module isqrt_share_arb #(
  parameter int N         = 4,
  parameter int ISQRT_LAT = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  input  logic [N*32-1:0] req_x,
  output logic [N-1:0]    req_rdy,
  output logic [N-1:0]    rsp_vld,
  output logic [31:0]     rsp_y,
  output logic            sq_x_vld,
  output logic [31:0]     sq_x,
  input  logic            sq_y_vld,
  input  logic [31:0]     sq_y,
  output logic            err
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [IW-1:0]        ptr_q, ptr_d, acc_id, iss_id_q, iss_id_d, tail_id, cand;
  logic [N-1:0]         elig, gnt, rsp_vld_q, rsp_vld_d, done_q, done_d;
  logic [CW-1:0]        out_q [N];
  logic [CW-1:0]        out_d [N];
  logic [ISQRT_LAT-1:0] tv_q, tv_d;
  logic [IW-1:0]        tid_q [ISQRT_LAT];
  logic [IW-1:0]        tid_d [ISQRT_LAT];
  logic [31:0]          sq_x_q, sq_x_d, rsp_y_q, rsp_y_d;
  logic                 sq_x_vld_q, sq_x_vld_d, err_q, err_d, accept, found, tail_v, ret;

  always_comb begin
    elig   = '0;
    gnt    = '0;
    acc_id = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) elig[i] = req_vld[i] && out_q[i] < CW'(MAX_OUT);
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        acc_id    = cand;
      end
    end
  end

  assign req_rdy = rst ? gnt : '0;
  assign accept  = |req_rdy;
  assign tail_v  = tv_q[ISQRT_LAT-1];
  assign tail_id = tid_q[ISQRT_LAT-1];
  assign ret     = sq_y_vld && tail_v;

  always_comb begin
    ptr_d      = accept ? ((acc_id == IW'(N - 1)) ? '0 : acc_id + 1'b1) : ptr_q;
    sq_x_vld_d = accept;
    sq_x_d     = accept ? req_x[32*acc_id +: 32] : sq_x_q;
    iss_id_d   = accept ? acc_id : iss_id_q;
    tv_d       = '0;
    tv_d[0]    = sq_x_vld_q;
    tid_d[0]   = sq_x_vld_q ? iss_id_q : tid_q[0];
    for (int k = 1; k < ISQRT_LAT; k++) begin
      tv_d[k]  = tv_q[k-1];
      tid_d[k] = tv_q[k-1] ? tid_q[k-1] : tid_q[k];
    end
    // a tail tag retires its owner's slot whether or not the isqrt delivered a result
    done_d    = tail_v ? (N'(1) << tail_id) : '0;
    rsp_vld_d = ret ? (N'(1) << tail_id) : '0;
    rsp_y_d   = ret ? sq_y : rsp_y_q;
    err_d     = err_q | (sq_y_vld ^ tail_v);
    for (int i = 0; i < N; i++)
      out_d[i] = out_q[i] + CW'(accept && acc_id == IW'(i)) - CW'(done_q[i] && out_q[i] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      sq_x_vld_q <= 1'b0;
      tv_q       <= '0;
      done_q     <= '0;
      rsp_vld_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < N; i++) out_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      sq_x_vld_q <= sq_x_vld_d;
      tv_q       <= tv_d;
      done_q     <= done_d;
      rsp_vld_q  <= rsp_vld_d;
      err_q      <= err_d;
      out_q      <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    sq_x_q   <= sq_x_d;
    iss_id_q <= iss_id_d;
    rsp_y_q  <= rsp_y_d;
    tid_q    <= tid_d;
  end

  assign sq_x_vld = sq_x_vld_q;
  assign sq_x     = sq_x_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_y    = rsp_y_q;
  assign err      = err_q;
endmodule

// File: tb/tb_isqrt_share_arb.sv
// tb_isqrt_share_arb: directed scenarios against a behavioural 16-stage isqrt hung off the DUT.
module tb_isqrt_share_arb;
  localparam int N = 4, LAT = 16;
  logic           clk = 1'b0, rst = 1'b0, stray = 1'b0;
  logic [N-1:0]   req_vld = '0, req_rdy, rsp_vld;
  logic [N*32-1:0] req_x = '0;
  logic [31:0]    rsp_y, sq_x, sq_y;
  logic           sq_x_vld, sq_y_vld, err;
  logic [LAT-1:0] pv = '0;
  logic [31:0]    py [LAT];
  int total = 0, passed = 0;

  isqrt_share_arb #(.N(N), .ISQRT_LAT(LAT), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .sq_x_vld(sq_x_vld), .sq_x(sq_x),
    .sq_y_vld(sq_y_vld), .sq_y(sq_y), .err(err));

  always #5 clk = ~clk;

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [31:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  // the shared isqrt is not reset, so it keeps emitting results issued before a DUT reset
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], sq_x_vld};
    py[0] <= isqrt(sq_x);
    for (int k = 1; k < LAT; k++) py[k] <= py[k-1];
  end
  assign sq_y_vld = pv[LAT-1] | stray;
  assign sq_y     = py[LAT-1];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_vld = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req_vld = '1;
    @(negedge clk); #1;
    total++; if (req_rdy !== 4'b0) $display("FAIL reset_rdy: got %b exp 0000", req_rdy); else passed++;
    total++; if (sq_x_vld !== 1'b0) $display("FAIL reset_sq_x_vld: got %b exp 0", sq_x_vld); else passed++;
    total++; if (rsp_vld !== 4'b0) $display("FAIL reset_rsp_vld: got %b exp 0000", rsp_vld); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b exp 0", err); else passed++;
    req_vld = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); req_vld = 4'b0001; req_x[31:0] = 32'd144; #1;
    total++; if (req_rdy !== 4'b0001) $display("FAIL single_rdy: got %b exp 0001", req_rdy); else passed++;
    @(negedge clk); req_vld = '0; #1;
    total++; if (sq_x_vld !== 1'b1 || sq_x !== 32'd144) $display("FAIL single_issue: got vld=%b x=%0d exp vld=1 x=144", sq_x_vld, sq_x); else passed++;
    repeat (16) @(negedge clk); #1;
    total++; if (rsp_vld !== 4'b0) $display("FAIL single_early: got %b exp 0000", rsp_vld); else passed++;
    @(negedge clk); #1;
    total++; if (rsp_vld !== 4'b0001 || rsp_y !== 32'd12) $display("FAIL single_rsp: got vld=%b y=%0d exp vld=0001 y=12", rsp_vld, rsp_y); else passed++;
    total++; if (err !== 1'b0) $display("FAIL single_err: got %b exp 0", err); else passed++;
    @(negedge clk); #1;
    total++; if (rsp_vld !== 4'b0 || rsp_y !== 32'd12) $display("FAIL single_pulse: got vld=%b y=%0d exp vld=0000 y=12", rsp_vld, rsp_y); else passed++;
  endtask

  task automatic test_contention();
    logic [31:0] ey [4] = '{32'd2, 32'd3, 32'd4, 32'd5};
    do_reset();
    req_x = {32'd25, 32'd16, 32'd9, 32'd4};
    for (int c = 0; c < 26; c++) begin
      @(negedge clk); req_vld = (c < 8) ? 4'hF : 4'h0; #1;
      if (c < 8) begin
        total++; if (req_rdy !== (4'b1 << (c % 4))) $display("FAIL rr_grant c=%0d: got %b exp %b", c, req_rdy, 4'b1 << (c % 4)); else passed++;
      end
      if (c >= 18) begin
        total++;
        if (rsp_vld !== (4'b1 << ((c - 18) % 4)) || rsp_y !== ey[(c - 18) % 4])
          $display("FAIL rr_rsp c=%0d: got vld=%b y=%0d exp vld=%b y=%0d", c, rsp_vld, rsp_y, 4'b1 << ((c - 18) % 4), ey[(c - 18) % 4]);
        else passed++;
      end
    end
  endtask

  task automatic test_limit();
    logic [3:0] er;
    do_reset();
    req_x[63:32] = 32'd49;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk); req_vld = (c < 31) ? 4'b0010 : 4'b0000; #1;
      er = (c <= 3 || (c >= 19 && c <= 22)) ? 4'b0010 : 4'b0000;
      if (c < 31) begin
        total++; if (req_rdy !== er) $display("FAIL limit_rdy c=%0d: got %b exp %b", c, req_rdy, er); else passed++;
      end
      if (c == 18) begin
        total++; if (rsp_vld !== 4'b0010 || rsp_y !== 32'd7) $display("FAIL limit_rsp: got vld=%b y=%0d exp vld=0010 y=7", rsp_vld, rsp_y); else passed++;
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] bx [3] = '{32'd0, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] by [3] = '{32'd0, 32'd65535, 32'd1};
    do_reset();
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      req_vld = (c < 3) ? (4'b1 << c) : 4'b0;
      if (c < 3) req_x[32*c +: 32] = bx[c];
      #1;
      if (c < 3) begin
        total++; if (req_rdy !== (4'b1 << c)) $display("FAIL bound_rdy c=%0d: got %b exp %b", c, req_rdy, 4'b1 << c); else passed++;
      end
      if (c >= 18) begin
        total++;
        if (rsp_vld !== (4'b1 << (c - 18)) || rsp_y !== by[c - 18])
          $display("FAIL bound_rsp x=%h: got vld=%b y=%0d exp vld=%b y=%0d", bx[c - 18], rsp_vld, rsp_y, 4'b1 << (c - 18), by[c - 18]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    do_reset();
    req_x = {4{32'd100}};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); req_vld = (c < 3) ? (4'b1 << c) : 4'b0;
    end
    @(negedge clk); rst = 1'b0; req_vld = 4'b0001; #1;
    total++; if (req_rdy !== 4'b0 || sq_x_vld !== 1'b0 || rsp_vld !== 4'b0) $display("FAIL mid_async: got rdy=%b sq=%b rsp=%b exp 0000 0 0000", req_rdy, sq_x_vld, rsp_vld); else passed++;
    @(negedge clk); #1;
    total++; if (req_rdy !== 4'b0) $display("FAIL mid_hold_rdy: got %b exp 0000", req_rdy); else passed++;
    @(negedge clk); rst = 1'b1; req_vld = '0;
    seen = '0;
    for (int c = 7; c < 25; c++) begin
      @(negedge clk); #1; seen |= rsp_vld;
    end
    total++; if (seen !== 4'b0) $display("FAIL mid_no_rsp: got %b exp 0000", seen); else passed++;
    req_x[63:32] = 32'd81;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk); req_vld = (c < 4) ? 4'b0010 : 4'b0000; #1;
      if (c < 4) begin
        total++; if (req_rdy !== 4'b0010) $display("FAIL mid_cnt_clear c=%0d: got %b exp 0010", c, req_rdy); else passed++;
      end
    end
    total++; if (rsp_vld !== 4'b0010 || rsp_y !== 32'd9) $display("FAIL mid_new_rsp: got vld=%b y=%0d exp vld=0010 y=9", rsp_vld, rsp_y); else passed++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_error();
    repeat (20) @(negedge clk);
    do_reset();
    @(negedge clk); #1;
    total++; if (err !== 1'b0) $display("FAIL err_clear: got %b exp 0", err); else passed++;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0; #1;
    total++; if (err !== 1'b1) $display("FAIL err_set: got %b exp 1", err); else passed++;
    total++; if (rsp_vld !== 4'b0) $display("FAIL err_drop: got %b exp 0000", rsp_vld); else passed++;
    repeat (5) @(negedge clk); #1;
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else passed++;
    @(negedge clk); req_vld = 4'b0100; req_x[95:64] = 32'd36; #1;
    total++; if (req_rdy !== 4'b0100) $display("FAIL err_traffic_rdy: got %b exp 0100", req_rdy); else passed++;
    @(negedge clk); req_vld = '0;
    repeat (16) @(negedge clk);
    @(negedge clk); #1;
    total++; if (rsp_vld !== 4'b0100 || rsp_y !== 32'd6 || err !== 1'b1) $display("FAIL err_traffic_rsp: got vld=%b y=%0d err=%b exp vld=0100 y=6 err=1", rsp_vld, rsp_y, err); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_limit();
    test_boundary();
    test_reset_mid();
    test_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
